// File: rtl/mem_if_pkg.sv
// Shared definitions for the data memory responder: FSM encoding, default
// sizing constants and the address legality check.
package mem_if_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int DEFAULT_DEPTH   = 32;
  localparam int DEFAULT_LATENCY = 2;

  // A request is illegal if it is not word aligned or its word index is past the array end.
  function automatic logic access_error(input logic [31:0] byte_addr, input int depth);
    return (byte_addr[1:0] != 2'b00) || ({2'b00, byte_addr[31:2]} >= 32'(depth));
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word storage for the responder: one synchronous write port and one
// asynchronous read port. Contents are not affected by reset.
module dmem_array #(
  parameter int DEPTH = 32,
  parameter int IDX_W = 5
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [31:0]      wdata,
  input  logic [IDX_W-1:0] raddr,
  output logic [31:0]      rdata
);

  logic [31:0] mem [DEPTH] = '{default: 32'h0};

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Indices past the end only occur on error transactions, whose data is discarded.
  assign rdata = (32'(raddr) < 32'(DEPTH)) ? mem[raddr] : 32'h0;

endmodule

// File: rtl/data_mem_responder.sv
// Fixed-latency data memory slave: accepts one load/store at a time and
// answers with a registered one-cycle ack after LATENCY cycles.
module data_mem_responder
  import mem_if_pkg::*;
#(
  parameter int DEPTH   = DEFAULT_DEPTH,
  parameter int LATENCY = DEFAULT_LATENCY
) (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ack,
  output logic        err,
  output logic [31:0] rdata,
  output logic        busy
);

  localparam int         IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  state_e state, next_state;
  logic [3:0]  cnt, cnt_next;
  logic        accept;
  logic        enter_resp;

  logic        lat_we;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;

  logic        cur_we;
  logic [31:0] cur_addr;
  logic [31:0] cur_wdata;
  logic        cur_err;
  logic [IDX_W-1:0] cur_idx;

  logic        array_we;
  logic [31:0] array_rdata;

  // In IDLE the live inputs describe the transaction (needed when LATENCY=1
  // enters RESP on the accepting edge); afterwards only the latched copy counts.
  assign cur_we    = (state == IDLE) ? we    : lat_we;
  assign cur_addr  = (state == IDLE) ? addr  : lat_addr;
  assign cur_wdata = (state == IDLE) ? wdata : lat_wdata;
  assign cur_err   = access_error(cur_addr, DEPTH);
  assign cur_idx   = cur_addr[IDX_W+1:2];

  assign accept   = (state == IDLE) && req;
  assign busy     = (state != IDLE);
  assign array_we = Resetn && enter_resp && cur_we && !cur_err;

  always_comb begin
    next_state = state;
    cnt_next   = cnt;
    enter_resp = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          if (LATENCY == 1) begin
            next_state = RESP;
            enter_resp = 1'b1;
          end else begin
            next_state = WAIT;
            cnt_next   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          next_state = RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_next = cnt - 4'd1;
        end
      end
      RESP: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
        cnt_next   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state <= IDLE;
      cnt   <= 4'd0;
      ack   <= 1'b0;
      err   <= 1'b0;
      rdata <= 32'h0;
    end else begin
      state <= next_state;
      cnt   <= cnt_next;
      ack   <= enter_resp;
      err   <= enter_resp && cur_err;
      rdata <= (enter_resp && !cur_we && !cur_err) ? array_rdata : 32'h0;
    end
  end

  // Request fields are captured once so later input changes cannot disturb the transfer.
  always_ff @(posedge Clock) begin
    if (accept) begin
      lat_we    <= we;
      lat_addr  <= addr;
      lat_wdata <= wdata;
    end
  end

  dmem_array #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_array (
    .clk   (Clock),
    .we    (array_we),
    .waddr (cur_idx),
    .wdata (cur_wdata),
    .raddr (cur_idx),
    .rdata (array_rdata)
  );

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: one instance at LATENCY=2 and one
// at LATENCY=1, both DEPTH=32, sharing clock and reset.
module tb_data_mem_responder;

  logic        Clock = 1'b0;
  logic        Resetn = 1'b0;

  logic        req0 = 1'b0, we0 = 1'b0;
  logic [31:0] addr0 = 32'h0, wdata0 = 32'h0;
  logic        ack0, err0, busy0;
  logic [31:0] rdata0;

  logic        req1 = 1'b0, we1 = 1'b0;
  logic [31:0] addr1 = 32'h0, wdata1 = 32'h0;
  logic        ack1, err1, busy1;
  logic [31:0] rdata1;

  int assert_count = 0;
  int fail_count   = 0;
  int ack0_total   = 0;
  int busy1_cycles = 0;

  always #5 Clock = ~Clock;

  data_mem_responder #(.DEPTH(32), .LATENCY(2)) dut (
    .Clock (Clock), .Resetn (Resetn), .req (req0), .we (we0), .addr (addr0),
    .wdata (wdata0), .ack (ack0), .err (err0), .rdata (rdata0), .busy (busy0)
  );

  data_mem_responder #(.DEPTH(32), .LATENCY(1)) dut_l1 (
    .Clock (Clock), .Resetn (Resetn), .req (req1), .we (we1), .addr (addr1),
    .wdata (wdata1), .ack (ack1), .err (err1), .rdata (rdata1), .busy (busy1)
  );

  always @(negedge Clock) begin
    if (ack0) ack0_total++;
    if (busy1) busy1_cycles++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assert_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Runs one transaction on the selected instance; called #1 after an edge with the DUT idle.
  task automatic applyStimulus(input int sel, input string tag, input logic w,
                               input logic [31:0] a, input logic [31:0] d,
                               input logic exp_err, input logic [31:0] exp_rdata,
                               input int exp_lat);
    int n;
    logic a_ack, a_err;
    logic [31:0] a_rdata;
    if (sel == 0) begin we0 = w; addr0 = a; wdata0 = d; req0 = 1'b1; end
    else          begin we1 = w; addr1 = a; wdata1 = d; req1 = 1'b1; end
    @(posedge Clock); #1;
    if (sel == 0) begin we0 = ~w; addr0 = 32'h3; wdata0 = ~d; end
    else          begin we1 = ~w; addr1 = 32'h3; wdata1 = ~d; end
    n = 1;
    a_ack = (sel == 0) ? ack0 : ack1;
    while (!a_ack && n < 20) begin
      @(posedge Clock); #1;
      n++;
      a_ack = (sel == 0) ? ack0 : ack1;
    end
    a_err   = (sel == 0) ? err0 : err1;
    a_rdata = (sel == 0) ? rdata0 : rdata1;
    checkOutput({tag, "_latency"}, n, exp_lat);
    checkOutput({tag, "_err"}, {31'b0, a_err}, {31'b0, exp_err});
    checkOutput({tag, "_rdata"}, a_rdata, exp_rdata);
    if (sel == 0) req0 = 1'b0; else req1 = 1'b0;
    @(posedge Clock); #1;
    a_ack = (sel == 0) ? ack0 : ack1;
    checkOutput({tag, "_ack_pulse"}, {31'b0, a_ack}, 32'h0);
  endtask

  initial begin
    int ack_cyc[3];
    int nacks, idle_low, cyc, ack_snap, busy_snap;
    logic [31:0] b2b_addr[3];
    logic [31:0] b2b_data[3];

    // Reset values
    repeat (2) @(posedge Clock);
    #1;
    checkOutput("reset_ack",   {31'b0, ack0},  32'h0);
    checkOutput("reset_err",   {31'b0, err0},  32'h0);
    checkOutput("reset_rdata", rdata0,         32'h0);
    checkOutput("reset_busy",  {31'b0, busy0}, 32'h0);
    Resetn = 1'b1;
    @(posedge Clock); #1;

    // Store then load, plus values used by later checks
    applyStimulus(0, "store_8",  1'b1, 32'h8,  32'hDEAD_BEEF, 1'b0, 32'h0, 2);
    applyStimulus(0, "load_8",   1'b0, 32'h8,  32'h0, 1'b0, 32'hDEAD_BEEF, 2);
    applyStimulus(0, "store_4",  1'b1, 32'h4,  32'h1234_5678, 1'b0, 32'h0, 2);
    applyStimulus(0, "store_c",  1'b1, 32'hC,  32'hCAFE_F00D, 1'b0, 32'h0, 2);

    // Misaligned and out-of-range accesses
    applyStimulus(0, "store_6_misalign", 1'b1, 32'h6, 32'hFFFF_FFFF, 1'b1, 32'h0, 2);
    applyStimulus(0, "load_4_after_err", 1'b0, 32'h4, 32'h0, 1'b0, 32'h1234_5678, 2);
    applyStimulus(0, "load_80_range",    1'b0, 32'h80, 32'h0, 1'b1, 32'h0, 2);
    applyStimulus(0, "load_7c_last",     1'b0, 32'h7C, 32'h0, 1'b0, 32'h0, 2);
    applyStimulus(0, "store_7c_last",    1'b1, 32'h7C, 32'h0BAD_CAFE, 1'b0, 32'h0, 2);
    applyStimulus(0, "load_7c_again",    1'b0, 32'h7C, 32'h0, 1'b0, 32'h0BAD_CAFE, 2);
    applyStimulus(0, "load_top_range",   1'b0, 32'hFFFF_FFFC, 32'h0, 1'b1, 32'h0, 2);

    // Back-to-back loads with req held high
    b2b_addr[0] = 32'h8; b2b_data[0] = 32'hDEAD_BEEF;
    b2b_addr[1] = 32'h4; b2b_data[1] = 32'h1234_5678;
    b2b_addr[2] = 32'hC; b2b_data[2] = 32'hCAFE_F00D;
    nacks = 0; idle_low = 0; cyc = 0;
    we0 = 1'b0; addr0 = b2b_addr[0]; req0 = 1'b1;
    while (nacks < 3 && cyc < 30) begin
      @(posedge Clock); #1;
      cyc++;
      if (nacks > 0 && !busy0) idle_low++;
      if (ack0) begin
        ack_cyc[nacks] = cyc;
        checkOutput($sformatf("b2b_rdata_%0d", nacks), rdata0, b2b_data[nacks]);
        nacks++;
        if (nacks < 3) addr0 = b2b_addr[nacks];
        else req0 = 1'b0;
      end
    end
    req0 = 1'b0;
    checkOutput("b2b_ack_count", nacks, 3);
    checkOutput("b2b_gap_01", ack_cyc[1] - ack_cyc[0], 3);
    checkOutput("b2b_gap_12", ack_cyc[2] - ack_cyc[1], 3);
    checkOutput("b2b_idle_cycles", idle_low, 2);
    @(posedge Clock); #1;

    // Reset during WAIT aborts the store
    ack_snap = ack0_total;
    we0 = 1'b1; addr0 = 32'hC; wdata0 = 32'h0BAD_BEEF; req0 = 1'b1;
    @(posedge Clock); #1;
    checkOutput("midreset_busy_wait", {31'b0, busy0}, 32'h1);
    #2 Resetn = 1'b0;
    #1;
    checkOutput("midreset_ack",   {31'b0, ack0},  32'h0);
    checkOutput("midreset_err",   {31'b0, err0},  32'h0);
    checkOutput("midreset_rdata", rdata0,         32'h0);
    checkOutput("midreset_busy",  {31'b0, busy0}, 32'h0);
    req0 = 1'b0;
    @(posedge Clock); #1;
    checkOutput("midreset_held_busy", {31'b0, busy0}, 32'h0);
    Resetn = 1'b1;
    repeat (3) @(posedge Clock);
    #1;
    checkOutput("midreset_no_ack", ack0_total - ack_snap, 0);
    applyStimulus(0, "load_c_after_reset", 1'b0, 32'hC, 32'h0, 1'b0, 32'hCAFE_F00D, 2);

    // LATENCY=1 instance never visits WAIT, so busy lasts one cycle per transfer
    busy_snap = busy1_cycles;
    applyStimulus(1, "l1_store_10", 1'b1, 32'h10, 32'hA5A5_A5A5, 1'b0, 32'h0, 1);
    applyStimulus(1, "l1_load_10",  1'b0, 32'h10, 32'h0, 1'b0, 32'hA5A5_A5A5, 1);
    checkOutput("l1_busy_cycles", busy1_cycles - busy_snap, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
